// File: rtl/fpdiv_ctrl.sv
// Sequencing controller for the Goldschmidt divider mantissa datapath.
// Define FPDIV_CTRL_ITER_OVERRIDE_EN to take the iteration count from iter_cnt at start.
module fpdiv_ctrl #(
    parameter int ITERS = 3
`ifdef FPDIV_CTRL_ITER_OVERRIDE_EN
    ,parameter int MAX_ITERS = 7
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
`ifdef FPDIV_CTRL_ITER_OVERRIDE_EN
    input  logic [3:0] iter_cnt,
`endif
    output logic       busy,
    output logic       done,
    output logic       sel_mux2,
    output logic [1:0] sel_mux4,
    output logic       en_a,
    output logic       en_b,
    output logic       en_c
);

    typedef enum logic [2:0] {
        IDLE,
        PRE_A,
        PRE_B,
        IT_A,
        IT_B,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] k_q, k_d;
    logic [3:0] nIter;
    logic       accept;

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

`ifdef FPDIV_CTRL_ITER_OVERRIDE_EN
    logic [3:0] n_q, n_d;

    // Zero is promoted to one iteration; anything beyond MAX_ITERS saturates.
    always_comb begin
        n_d = n_q;
        if (accept) begin
            if (iter_cnt == 4'd0) begin
                n_d = 4'd1;
            end else if (iter_cnt > 4'(MAX_ITERS)) begin
                n_d = 4'(MAX_ITERS);
            end else begin
                n_d = iter_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_q <= 4'(ITERS);
        end else begin
            n_q <= n_d;
        end
    end

    assign nIter = n_q;
`else
    assign nIter = 4'(ITERS);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= 4'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PRE_A;
                    k_d     = 4'd0;
                end
            end
            PRE_A: state_d = PRE_B;
            PRE_B: state_d = IT_A;
            IT_A: begin
                // The final iteration leaves straight for DONE; its B/C update would be dead.
                k_d = k_q + 4'd1;
                if ((k_q + 4'd1) == nIter) begin
                    state_d = DONE;
                end else begin
                    state_d = IT_B;
                end
            end
            IT_B: state_d = IT_A;
            DONE: begin
                if (accept) begin
                    state_d = PRE_A;
                    k_d     = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        sel_mux2 = 1'b0;
        sel_mux4 = 2'b00;
        en_a     = 1'b0;
        en_b     = 1'b0;
        en_c     = 1'b0;
        case (state_q)
            PRE_A: begin
                busy = 1'b1;
                en_a = 1'b1;
            end
            PRE_B: begin
                busy     = 1'b1;
                sel_mux4 = 2'b01;
                en_b     = 1'b1;
                en_c     = 1'b1;
            end
            IT_A: begin
                busy     = 1'b1;
                sel_mux2 = 1'b1;
                sel_mux4 = 2'b10;
                en_a     = 1'b1;
            end
            IT_B: begin
                busy     = 1'b1;
                sel_mux2 = 1'b1;
                sel_mux4 = 2'b11;
                en_b     = 1'b1;
                en_c     = 1'b1;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/fpdiv_ctrl.md
# fpdiv_ctrl

Sequencing controller for the Goldschmidt floating-point divider mantissa datapath (`fpdiv`). It drives the datapath's multiplier-input selects and its A/B/C register enables through a fixed prescale-then-iterate schedule, and exposes a start/busy/done handshake to the FP unit's issue logic. It contains no arithmetic. The quotient is read from the datapath's A register when `done` pulses.

## Interface
Parameters:
- `ITERS`, 3: Goldschmidt iterations per divide; legal range 1..15.
- `MAX_ITERS`, 7: upper bound for the runtime iteration count. Present only with `FPDIV_CTRL_ITER_OVERRIDE_EN`.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request a divide. Sampled in IDLE or DONE.
- `iter_cnt`  in  4: runtime iteration count, sampled with an accepted `start`. Present only with the macro.
- `busy`  out  1: divide in progress.
- `done`  out  1: one-cycle pulse; datapath A register holds the quotient.
- `sel_mux2`  out  1: 0 = initial approximation, 1 = C register.
- `sel_mux4`  out  2: 00 = num, 01 = denom, 10 = A reg, 11 = B reg.
- `en_a`, `en_b`, `en_c`  out  1 each: datapath register load enables.

## Operation
- States: IDLE, PRE_A, PRE_B, IT_A, IT_B, DONE. All outputs are Moore, decoded from the state.
- IDLE: all enables 0, `sel_mux2`=0, `sel_mux4`=00, `busy`=0, `done`=0.
- PRE_A: `sel_mux2`=0, `sel_mux4`=00, `en_a`=1, so A ← N·K0. Next state is PRE_B.
- PRE_B: `sel_mux2`=0, `sel_mux4`=01, `en_b`=`en_c`=1, so B ← D·K0 and C ← ~(D·K0). Next state is IT_A.
- IT_A: `sel_mux2`=1, `sel_mux4`=10, `en_a`=1, so A ← A·C. Increment the iteration counter `k`.
  - If `k`==N after the increment, go to DONE.
  - Otherwise go to IT_B.
- IT_B: `sel_mux2`=1, `sel_mux4`=11, `en_b`=`en_c`=1, so B ← B·C and C ← ~(B·C). Next state is IT_A.
- The last iteration skips IT_B; the B/C update would be unused.
- DONE: `done`=1, `busy`=0, all enables 0, selects at their IDLE values.
  - With `start`=1, go to PRE_A (back-to-back divide).
  - Otherwise go to IDLE.
- `start` in any other state is ignored and is not queued.
- `busy`=1 exactly in PRE_A, PRE_B, IT_A and IT_B.
- `k` is 4 bits and is cleared on an accepted `start`.
- N = `ITERS` with the macro absent.
- Operand rule: the controller does not latch `num`/`denom`. Upstream holds them stable from the accepted `start` through PRE_B.
- Invariants:
  - At most one of {A-write, B/C-write} per cycle.
  - `en_b` and `en_c` are always asserted together.
  - `en_a` is never asserted together with `en_b`.

## Timing
- Reset: state returns to IDLE on the next edge and `k`=0. All outputs are at IDLE values in the following cycle.
- Reset mid-divide aborts the divide:
  - no `done` is produced;
  - datapath register contents are don't-care.
- Reset has priority over `start` when both are high on the same edge.
- `start` is high at edge t (state IDLE or DONE):
  - PRE_A occupies cycle t+1.
  - PRE_B occupies cycle t+2.
  - IT_A/IT_B alternate from t+3.
  - `done` is high in cycle t+2+2N.
- Total latency is 2N+2 cycles from accept to `done`. Throughput is one divide per 2N+2 cycles using DONE→PRE_A.
- Each `en_*` is high for exactly one cycle per write. The select values are valid in the same cycle as their enable (single-cycle combinational multiply).

## Configuration
- `FPDIV_CTRL_ITER_OVERRIDE_EN` defined:
  - The `iter_cnt` port and the `MAX_ITERS` parameter exist.
  - N is `iter_cnt`, sampled on the accepted `start` and held in a register for the whole divide.
  - `iter_cnt`=0 is treated as 1.
  - Values above `MAX_ITERS` are clamped to `MAX_ITERS`.
- Not defined:
  - Neither the port nor the parameter exists.
  - N = `ITERS` is fixed at elaboration.
  - Behaviour is otherwise identical.

## Test plan
- Basic sequence, ITERS=3, `start` pulsed at edge 0:
  - cycles 1..7 show `sel_mux4` = 00,01,10,11,10,11,10;
  - `en_a` high in cycles 1,3,5,7;
  - `en_b`/`en_c` high in cycles 2,4,6;
  - `done` high only in cycle 8;
  - `busy` high in cycles 1..7.
- Ignored start, ITERS=3: `start` held high continuously from edge 0 until cycle 5, then low:
  - `start` held high in cycles 1..5 has no effect;
  - `done` still occurs only in cycle 8, followed by return to IDLE.
- Back-to-back: `start` high in the DONE cycle (8) → PRE_A in cycle 9, next `done` in cycle 16, no idle bubble.
- Reset mid-op: `reset` asserted in cycle 4 of a divide:
  - cycle 5 shows IDLE outputs;
  - no `done` appears;
  - a new `start` then completes normally.
- Integrated with `fpdiv`, ITERS=3, num=1.5, denom=1.25 (1.26 fixed point in 27 bits) → at `done`, A holds 1.2 within 2^-20.
- With the macro defined:
  - `iter_cnt`=1 → `done` at t+4, and `en_b` fires only in PRE_B;
  - `iter_cnt`=0 → same as 1;
  - `iter_cnt`=12 with `MAX_ITERS`=7 → `done` at t+16.
